// File: rtl/dma_timing_control.sv
// 8237A-style DMA timing and priority controller: four-channel arbitration,
// HRQ/HLDA handshake and SI/S0/S1/S2/S3/SW/S4 transfer sequencing (Moore outputs).
module dma_timing_control #(
    parameter int NUM_CH = 4
) (
    input  logic                  CLK,
    input  logic                  RESET_N,
    input  logic [NUM_CH-1:0]     DREQ,
    input  logic                  HLDA,
    input  logic                  READY,
    input  logic                  EOP_N,
    input  logic                  TC,
    input  logic                  UPPER_CHG,
    input  logic                  ROTATE,
    input  logic [2*NUM_CH-1:0]   XFER_TYPE,
    input  logic [NUM_CH-1:0]     BLOCK_MODE,
    output logic                  HRQ,
    output logic                  AEN,
    output logic                  ADSTB,
    output logic [NUM_CH-1:0]     DACK,
    output logic [1:0]            CH_SEL,
    output logic                  MEMR_N,
    output logic                  MEMW_N,
    output logic                  IOR_N,
    output logic                  IOW_N,
    output logic                  ADDR_UPD,
    output logic                  EOP_OUT_N
);

    typedef enum logic [2:0] {
        SI = 3'd0,
        S0 = 3'd1,
        S1 = 3'd2,
        S2 = 3'd3,
        S3 = 3'd4,
        SW = 3'd5,
        S4 = 3'd6
    } state_t;

    state_t      state;
    state_t      state_n;
    logic [1:0]  ch_sel;
    logic [1:0]  xtype;
    logic        blk;
    logic [1:0]  last_ch;
    logic        eop_seen;
    logic        end_r;

    logic        any_req;
    logic        found;
    logic [1:0]  win;
    logic [1:0]  idx;
    logic        end_now;

    assign any_req = |DREQ;

    // Rotating search starts one past the last serviced channel; reset leaves
    // last_ch at 3 so channel 0 is searched first.
    always_comb begin
        found = 1'b0;
        win   = 2'd0;
        idx   = 2'd0;
        if (ROTATE) begin
            for (int unsigned i = 1; i <= 4; i++) begin
                idx = last_ch + 2'(i);
                if (!found && DREQ[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end else begin
            for (int unsigned i = 0; i < 4; i++) begin
                idx = 2'(i);
                if (!found && DREQ[idx]) begin
                    found = 1'b1;
                    win   = idx;
                end
            end
        end
    end

    assign end_now = end_r | ~EOP_N;

    always_comb begin
        state_n = state;
        case (state)
            SI: if (any_req) state_n = S0;
            S0: if (HLDA) state_n = S1;
            S1: state_n = HLDA ? S2 : SI;
            S2: state_n = HLDA ? S3 : SI;
            S3, SW: begin
                if (!HLDA)
                    state_n = SI;
                else if (READY)
                    state_n = S4;
                else
                    state_n = SW;
            end
            S4: begin
                if (end_now || !blk || !HLDA)
                    state_n = SI;
                else if (UPPER_CHG)
                    state_n = S1;
                else
                    state_n = S2;
            end
            default: state_n = SI;
        endcase
    end

    always_ff @(posedge CLK or negedge RESET_N) begin
        if (!RESET_N) begin
            state    <= SI;
            ch_sel   <= 2'd0;
            xtype    <= 2'b00;
            blk      <= 1'b0;
            last_ch  <= 2'd3;
            eop_seen <= 1'b0;
            end_r    <= 1'b0;
        end else begin
            state <= state_n;
            if (state == SI && any_req) begin
                ch_sel <= win;
                xtype  <= XFER_TYPE[{win, 1'b0} +: 2];
                blk    <= BLOCK_MODE[win];
            end
            // Only a completed transfer moves the rotation pointer; aborts leave it.
            if (state == S4 && state_n == SI)
                last_ch <= ch_sel;
            if (state == S2 || state == S3 || state == SW)
                eop_seen <= eop_seen | ~EOP_N;
            else
                eop_seen <= 1'b0;
            // Termination is decided on entry to S4 so EOP_OUT_N stays a pure state decode.
            if (state_n == S4)
                end_r <= TC | ~EOP_N | eop_seen;
            else
                end_r <= 1'b0;
        end
    end

    always_comb begin
        HRQ       = (state != SI);
        AEN       = 1'b0;
        ADSTB     = 1'b0;
        DACK      = '0;
        CH_SEL    = ch_sel;
        MEMR_N    = 1'b1;
        MEMW_N    = 1'b1;
        IOR_N     = 1'b1;
        IOW_N     = 1'b1;
        ADDR_UPD  = 1'b0;
        EOP_OUT_N = 1'b1;
        case (state)
            S1: begin
                AEN          = 1'b1;
                ADSTB        = 1'b1;
                DACK[ch_sel] = 1'b1;
            end
            S2: begin
                AEN          = 1'b1;
                DACK[ch_sel] = 1'b1;
                MEMR_N       = ~(xtype == 2'b10);
                IOR_N        = ~(xtype == 2'b01);
            end
            S3, SW: begin
                AEN          = 1'b1;
                DACK[ch_sel] = 1'b1;
                MEMR_N       = ~(xtype == 2'b10);
                IOR_N        = ~(xtype == 2'b01);
                IOW_N        = ~(xtype == 2'b10);
                MEMW_N       = ~(xtype == 2'b01);
            end
            S4: begin
                AEN          = 1'b1;
                DACK[ch_sel] = 1'b1;
                ADDR_UPD     = 1'b1;
                EOP_OUT_N    = ~end_r;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_dma_timing_control.sv
// Self-checking bench for dma_timing_control: table of grant scenarios checked
// through an expected-result queue, plus abort and mid-transfer reset sequences.
module tb_dma_timing_control;

    logic       CLK = 1'b0;
    logic       RESET_N;
    logic [3:0] DREQ;
    logic       HLDA, READY, EOP_N, TC, UPPER_CHG, ROTATE;
    logic [7:0] XFER_TYPE;
    logic [3:0] BLOCK_MODE;
    logic       HRQ, AEN, ADSTB;
    logic [3:0] DACK;
    logic [1:0] CH_SEL;
    logic       MEMR_N, MEMW_N, IOR_N, IOW_N, ADDR_UPD, EOP_OUT_N;

    int total = 0;
    int bad   = 0;

    dma_timing_control #(.NUM_CH(4)) dut (
        .CLK(CLK), .RESET_N(RESET_N), .DREQ(DREQ), .HLDA(HLDA), .READY(READY),
        .EOP_N(EOP_N), .TC(TC), .UPPER_CHG(UPPER_CHG), .ROTATE(ROTATE),
        .XFER_TYPE(XFER_TYPE), .BLOCK_MODE(BLOCK_MODE), .HRQ(HRQ), .AEN(AEN),
        .ADSTB(ADSTB), .DACK(DACK), .CH_SEL(CH_SEL), .MEMR_N(MEMR_N),
        .MEMW_N(MEMW_N), .IOR_N(IOR_N), .IOW_N(IOW_N), .ADDR_UPD(ADDR_UPD),
        .EOP_OUT_N(EOP_OUT_N)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit         do_reset;
        bit         rotate;
        logic [3:0] dreq;
        logic [7:0] xtype;
        logic [3:0] block;
        bit         upper;
        int         dly, waits, tc_on, eop_on;
        int         ch, dack, memr, memw, ior, iow, adstb, upd, upd_at, eop, len;
    } vec_t;

    vec_t exp_q[$];
    vec_t tbl[14];

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic idle_inputs();
        DREQ = 4'b0000; HLDA = 1'b0; READY = 1'b1; EOP_N = 1'b1; TC = 1'b0;
        UPPER_CHG = 1'b0;
    endtask

    task automatic apply_reset();
        idle_inputs();
        RESET_N = 1'b0;
        repeat (2) @(negedge CLK);
        RESET_N = 1'b1;
    endtask

    task automatic chk_reset_vals(input string p);
        chk({p, "_hrq"}, int'(HRQ), 0);
        chk({p, "_aen"}, int'(AEN), 0);
        chk({p, "_adstb"}, int'(ADSTB), 0);
        chk({p, "_dack"}, int'(DACK), 0);
        chk({p, "_chsel"}, int'(CH_SEL), 0);
        chk({p, "_strobes"}, int'({MEMR_N, MEMW_N, IOR_N, IOW_N}), 15);
        chk({p, "_upd"}, int'(ADDR_UPD), 0);
        chk({p, "_eopout"}, int'(EOP_OUT_N), 1);
    endtask

    // Runs one grant, acting as CPU (HLDA) and slave device (READY/TC/EOP),
    // and measures strobe activity while HRQ is high.
    task automatic run_vec(input vec_t v, input int id);
        vec_t e, o;
        int   hrq_cnt, pos, xfer, wcnt;
        bit   prev_upd, done, started, got_ch;
        string s;
        o = v;
        o.ch = -1; o.dack = -1; o.memr = 0; o.memw = 0; o.ior = 0; o.iow = 0;
        o.adstb = 0; o.upd = 0; o.upd_at = 0; o.eop = 0; o.len = 0;
        hrq_cnt = 0; pos = 0; xfer = 0; wcnt = 0;
        prev_upd = 0; done = 0; started = 0; got_ch = 0;
        if (v.do_reset) apply_reset();
        exp_q.push_back(v);
        @(negedge CLK);
        ROTATE = v.rotate; XFER_TYPE = v.xtype; BLOCK_MODE = v.block;
        UPPER_CHG = v.upper; READY = 1'b1; TC = 1'b0; EOP_N = 1'b1; HLDA = 1'b0;
        DREQ = v.dreq;
        for (int c = 0; c < 300 && !done; c++) begin
            @(negedge CLK);
            if (HRQ) begin
                started = 1;
                hrq_cnt++;
                o.memr += int'(!MEMR_N); o.memw += int'(!MEMW_N);
                o.ior  += int'(!IOR_N);  o.iow  += int'(!IOW_N);
                o.adstb += int'(ADSTB);  o.upd  += int'(ADDR_UPD);
                o.eop  += int'(!EOP_OUT_N);
                if (ADDR_UPD && o.upd_at == 0) o.upd_at = hrq_cnt;
                if (ADSTB && !got_ch) begin
                    got_ch = 1; o.ch = int'(CH_SEL); o.dack = int'(DACK);
                end
                if (!AEN && hrq_cnt >= v.dly) HLDA = 1'b1;
                if (ADSTB) begin
                    pos = 1; xfer++;
                end else if (prev_upd && AEN) begin
                    pos = 2; xfer++;
                end else begin
                    pos++;
                end
                EOP_N = 1'b1;
                if (pos == 3) begin
                    if (xfer == 1) wcnt = v.waits;
                    if (xfer == v.tc_on) TC = 1'b1;
                    if (xfer == v.eop_on) EOP_N = 1'b0;
                end
                READY = (wcnt == 0);
                if (wcnt > 0) wcnt--;
                if (ADDR_UPD) TC = 1'b0;
                prev_upd = ADDR_UPD;
            end else if (started) begin
                done = 1;
            end
        end
        o.len = hrq_cnt;
        idle_inputs();
        s = $sformatf("v%0d", id);
        if (!done) chk({s, "_timeout"}, 0, 1);
        e = exp_q.pop_front();
        chk({s, "_ch"},     o.ch,     e.ch);
        chk({s, "_dack"},   o.dack,   e.dack);
        chk({s, "_memr"},   o.memr,   e.memr);
        chk({s, "_memw"},   o.memw,   e.memw);
        chk({s, "_ior"},    o.ior,    e.ior);
        chk({s, "_iow"},    o.iow,    e.iow);
        chk({s, "_adstb"},  o.adstb,  e.adstb);
        chk({s, "_upd"},    o.upd,    e.upd);
        chk({s, "_upd_at"}, o.upd_at, e.upd_at);
        chk({s, "_eopout"}, o.eop,    e.eop);
        chk({s, "_len"},    o.len,    e.len);
    endtask

    task automatic wait_hrq_grant(input string nm);
        bit seen;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (HRQ) begin seen = 1; HLDA = 1'b1; end
        end
        if (!seen) chk({nm, "_hrq_timeout"}, 0, 1);
    endtask

    task automatic wait_s1(input string nm);
        bit seen;
        seen = 0;
        for (int c = 0; c < 20 && !seen; c++) begin
            @(negedge CLK);
            if (ADSTB) seen = 1;
        end
        if (!seen) chk({nm, "_s1_timeout"}, 0, 1);
    endtask

    initial begin
        vec_t v;
        idle_inputs();
        ROTATE = 1'b0; XFER_TYPE = 8'h00; BLOCK_MODE = 4'b0000;
        RESET_N = 1'b0;
        DREQ = 4'b1111;
        repeat (3) @(negedge CLK);
        chk_reset_vals("por");
        DREQ = 4'b0000;
        RESET_N = 1'b1;

        //         rst rot dreq     type   block    up dly w tc eop | ch dack memr memw ior iow adstb upd upd_at eop len
        tbl[0]  = '{1, 0, 4'b0110, 8'hAA, 4'b0000, 0, 2, 0, 0, 0,  1, 2, 2, 0, 0, 1, 1, 1, 6, 0, 6};
        tbl[1]  = '{0, 0, 4'b1000, 8'h55, 4'b0000, 0, 1, 0, 0, 0,  3, 8, 0, 1, 2, 0, 1, 1, 5, 0, 5};
        tbl[2]  = '{0, 0, 4'b1100, 8'h00, 4'b0000, 0, 1, 0, 0, 0,  2, 4, 0, 0, 0, 0, 1, 1, 5, 0, 5};
        tbl[3]  = '{0, 0, 4'b0001, 8'hAA, 4'b0000, 0, 1, 3, 0, 0,  0, 1, 5, 0, 0, 4, 1, 1, 8, 0, 8};
        tbl[4]  = '{0, 0, 4'b0100, 8'hAA, 4'b0100, 0, 1, 0, 4, 0,  2, 4, 8, 0, 0, 4, 1, 4, 5, 1, 14};
        tbl[5]  = '{0, 0, 4'b0100, 8'hAA, 4'b0100, 1, 1, 0, 2, 0,  2, 4, 4, 0, 0, 2, 2, 2, 5, 1, 9};
        tbl[6]  = '{0, 0, 4'b0100, 8'hAA, 4'b0100, 0, 1, 0, 0, 2,  2, 4, 4, 0, 0, 2, 1, 2, 5, 1, 8};
        tbl[7]  = '{1, 1, 4'b1111, 8'hAA, 4'b0000, 0, 1, 0, 0, 0,  0, 1, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        tbl[8]  = '{0, 1, 4'b1111, 8'hAA, 4'b0000, 0, 1, 0, 0, 0,  1, 2, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        tbl[9]  = '{0, 1, 4'b1111, 8'hAA, 4'b0000, 0, 1, 0, 0, 0,  2, 4, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        tbl[10] = '{0, 1, 4'b1111, 8'hAA, 4'b0000, 0, 1, 0, 0, 0,  3, 8, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        tbl[11] = '{0, 1, 4'b1111, 8'hAA, 4'b0000, 0, 1, 0, 0, 0,  0, 1, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        tbl[12] = '{0, 1, 4'b0011, 8'hAA, 4'b0000, 0, 1, 0, 0, 0,  1, 2, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        tbl[13] = '{0, 0, 4'b0001, 8'hAA, 4'b0000, 0, 1, 0, 1, 0,  0, 1, 2, 0, 0, 1, 1, 1, 5, 1, 5};

        for (int i = 0; i < 14; i++) run_vec(tbl[i], i);

        // HLDA lost in S2: abort without ADDR_UPD, rotation pointer stays at ch0.
        @(negedge CLK);
        ROTATE = 1'b1; XFER_TYPE = 8'hAA; BLOCK_MODE = 4'b0000; DREQ = 4'b0100;
        wait_hrq_grant("abort");
        wait_s1("abort");
        chk("abort_s1_upd", int'(ADDR_UPD), 0);
        @(negedge CLK);
        chk("abort_s2_memr", int'(MEMR_N), 0);
        chk("abort_s2_upd", int'(ADDR_UPD), 0);
        HLDA = 1'b0;
        @(negedge CLK);
        chk("abort_hrq", int'(HRQ), 0);
        chk("abort_aen", int'(AEN), 0);
        chk("abort_dack", int'(DACK), 0);
        chk("abort_memr_rel", int'(MEMR_N), 1);
        chk("abort_upd", int'(ADDR_UPD), 0);
        idle_inputs();
        v = '{0, 1, 4'b1100, 8'hAA, 4'b0000, 0, 1, 0, 0, 0, 2, 4, 2, 0, 0, 1, 1, 1, 5, 0, 5};
        run_vec(v, 14);

        // Asynchronous reset while parked in SW.
        @(negedge CLK);
        ROTATE = 1'b0; DREQ = 4'b0100;
        wait_hrq_grant("rstsw");
        wait_s1("rstsw");
        @(negedge CLK);
        READY = 1'b0;
        @(negedge CLK);
        @(negedge CLK);
        chk("rstsw_memr", int'(MEMR_N), 0);
        chk("rstsw_iow", int'(IOW_N), 0);
        chk("rstsw_chsel", int'(CH_SEL), 2);
        #2 RESET_N = 1'b0;
        #1 chk_reset_vals("rstsw");
        idle_inputs();
        @(negedge CLK);
        RESET_N = 1'b1;
        @(negedge CLK);
        chk("rstsw_after_hrq", int'(HRQ), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
